comm_cs_initiator: RTL

- Control-system-side bus initiator that drives the peripheral block's external (cs) request port.
- Accepts byte-serial command frames from the host link receiver and converts each one into a single read or write transaction on the cs port.
- Returns read data or a write acknowledge as a byte stream to the host link transmitter.
- Sits between the host serial front end and the peripheral register file.

---
 rtl/comm_cs_initiator_pkg.sv | 23 ++
 rtl/comm_cs_byte_serializer.sv | 41 ++++
 rtl/comm_cs_initiator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/comm_cs_initiator_pkg.sv
// rtl/comm_cs_initiator_pkg.sv - opcodes, response bytes and FSM encoding shared by the cs initiator
package comm_cs_initiator_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    S_OP    = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_ERR   = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  function automatic logic is_valid_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/comm_cs_byte_serializer.sv
// rtl/comm_cs_byte_serializer.sv - MSB-first response byte shifter with valid/ready handshake
module comm_cs_byte_serializer (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [31:0] r_shift;
  logic [2:0]  r_left;
  logic        r_valid;
  logic        w_fire;

  assign w_fire = r_valid & tx_ready_i;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_shift <= 32'h0;
      r_left  <= 3'd0;
      r_valid <= 1'b0;
    end else if (load_i) begin
      r_shift <= data_i;
      r_left  <= nbytes_i;
      r_valid <= (nbytes_i != 3'd0);
    end else if (w_fire) begin
      r_shift <= {r_shift[23:0], 8'h00};
      r_left  <= r_left - 3'd1;
      r_valid <= (r_left != 3'd1);
    end
  end

  assign tx_valid_o = r_valid;
  assign tx_data_o  = r_shift[31:24];
  assign done_o     = w_fire & (r_left == 3'd1);

endmodule

// File: rtl/comm_cs_initiator.sv
// rtl/comm_cs_initiator.sv - host byte frames to single cs-port read/write transactions
// Optional inter-byte timeout enabled by defining COMM_CS_TIMEOUT_EN.
module comm_cs_initiator #(
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        req_cs_o,
  output logic        rw_cs_o,
  output logic [26:0] add_cs_o,
  output logic [31:0] data_cs_o,
  input  logic [31:0] data_cs_i,
  output logic        busy_o
);
  import comm_cs_initiator_pkg::*;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_is_write;
  logic [26:0] r_addr_sh;
  logic [31:0] r_data_sh;
  logic        r_rx_ready;
  logic        r_busy;
  logic        r_req;
  logic        r_rw;
  logic [26:0] r_add;
  logic [31:0] r_wdata;
  logic        r_ser_load;
  logic [31:0] r_ser_data;
  logic [2:0]  r_ser_n;

  logic        w_rx_fire;
  logic        w_ser_done;
  logic        w_timeout;

  assign w_rx_fire = rx_valid_i & r_rx_ready;

`ifdef COMM_CS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle;
  logic          w_in_field;

  assign w_in_field = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_timeout  = w_in_field & ~w_rx_fire & (r_idle == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_idle <= '0;
    end else if (w_in_field && !w_rx_fire && !w_timeout) begin
      r_idle <= r_idle + 1'b1;
    end else begin
      r_idle <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // rx_ready/busy are registered alongside each transition so they track r_state exactly,
  // except that rx_ready stays low for the first cycle out of reset.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= S_OP;
      r_cnt      <= 3'd0;
      r_is_write <= 1'b0;
      r_addr_sh  <= 27'h0;
      r_data_sh  <= 32'h0;
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_req      <= 1'b0;
      r_rw       <= 1'b0;
      r_add      <= 27'h0;
      r_wdata    <= 32'h0;
      r_ser_load <= 1'b0;
      r_ser_data <= 32'h0;
      r_ser_n    <= 3'd0;
    end else begin
      r_req      <= 1'b0;
      r_ser_load <= 1'b0;
      case (r_state)
        S_OP: begin
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            r_busy     <= 1'b1;
            r_cnt      <= 3'd0;
            r_is_write <= (rx_data_i == OP_WRITE);
            if (is_valid_op(rx_data_i)) begin
              r_state <= S_ADDR;
            end else begin
              r_state    <= S_ERR;
              r_rx_ready <= 1'b0;
            end
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr_sh <= {r_addr_sh[18:0], rx_data_i};
            if (r_cnt == 3'd3) begin
              r_cnt <= 3'd0;
              if (r_is_write) begin
                r_state <= S_DATA;
              end else begin
                r_state    <= S_ISSUE;
                r_rx_ready <= 1'b0;
                r_req      <= 1'b1;
                r_rw       <= 1'b0;
                r_add      <= {r_addr_sh[18:0], rx_data_i};
              end
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_rx_ready <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_rx_fire) begin
            r_data_sh <= {r_data_sh[23:0], rx_data_i};
            if (r_cnt == 3'd3) begin
              r_cnt      <= 3'd0;
              r_state    <= S_ISSUE;
              r_rx_ready <= 1'b0;
              r_req      <= 1'b1;
              r_rw       <= 1'b1;
              r_add      <= r_addr_sh;
              r_wdata    <= {r_data_sh[23:0], rx_data_i};
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_rx_ready <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_cnt <= 3'd0;
          if (r_is_write) begin
            r_ser_load <= 1'b1;
            r_ser_data <= {RSP_ACK, 24'h0};
            r_ser_n    <= 3'd1;
            r_state    <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'(RD_LATENCY - 1)) begin
            r_cnt      <= 3'd0;
            r_ser_load <= 1'b1;
            r_ser_data <= data_cs_i;
            r_ser_n    <= 3'd4;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_ERR: begin
          r_cnt      <= 3'd0;
          r_ser_load <= 1'b1;
          r_ser_data <= {RSP_ERR, 24'h0};
          r_ser_n    <= 3'd1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (w_ser_done) begin
            r_cnt      <= 3'd0;
            r_state    <= S_OP;
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_OP;
          r_busy     <= 1'b0;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  comm_cs_byte_serializer u_ser (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (r_ser_load),
    .data_i     (r_ser_data),
    .nbytes_i   (r_ser_n),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .done_o     (w_ser_done)
  );

  assign rx_ready_o = r_rx_ready;
  assign busy_o     = r_busy;
  assign req_cs_o   = r_req;
  assign rw_cs_o    = r_rw;
  assign add_cs_o   = r_add;
  assign data_cs_o  = r_wdata;

endmodule
